// File: rtl/trivial_derotator_stream.sv
//============================================================================
// Module   : trivial_derotator_stream
// Brief    : Streaming x1 / x(+i) derotator for the 16-point IFFT output path,
//            valid/ready on both sides, registered output plus one skid entry.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module trivial_derotator_stream #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   BLOCK_LEN  = 16,
  parameter logic [BLOCK_LEN-1:0] FLIP_MASK  = 16'hF000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cnt_clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         ip_r,
  input  logic [DATA_WIDTH-1:0]         ip_im,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_r,
  output logic [DATA_WIDTH-1:0]         out_i,
  output logic [$clog2(BLOCK_LEN)-1:0]  out_idx,
  output logic                          out_sat
);

  localparam int                  IDX_W      = $clog2(BLOCK_LEN);
  localparam int                  PAY_W      = 2*DATA_WIDTH + IDX_W + 1;
  localparam logic [IDX_W-1:0]    c_LAST_IDX = IDX_W'(BLOCK_LEN-1);
  localparam logic [IDX_W-1:0]    c_ONE      = IDX_W'(1);
  localparam logic [DATA_WIDTH-1:0] c_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [IDX_W-1:0]      r_cnt;
  logic                  r_out_valid;
  logic [PAY_W-1:0]      r_out_pay;
  logic [PAY_W-1:0]      r_skid_pay;
  // Skid occupancy is stored inverted so in_ready comes straight off a flop.
  logic                  r_in_ready;

  logic                  w_acc;
  logic                  w_out_free;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_flip;
  logic                  w_im_min;
  logic [DATA_WIDTH-1:0] w_neg_im;
  logic [DATA_WIDTH-1:0] w_rot_r;
  logic [DATA_WIDTH-1:0] w_rot_i;
  logic                  w_rot_sat;
  logic [PAY_W-1:0]      w_pay;

  assign w_acc      = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_idx      = cnt_clr ? '0 : r_cnt;
  assign w_flip     = FLIP_MASK[w_idx];

  // Negating the most-negative value would overflow; clamp to most-positive.
  assign w_im_min   = (ip_im == c_MIN);
  assign w_neg_im   = w_im_min ? c_MAX : (~ip_im + {{(DATA_WIDTH-1){1'b0}}, 1'b1});

  always_comb begin
    w_rot_r   = ip_r;
    w_rot_i   = ip_im;
    w_rot_sat = 1'b0;
    if (w_flip) begin
      w_rot_r   = w_neg_im;
      w_rot_i   = ip_r;
      w_rot_sat = w_im_min;
    end
  end

  assign w_pay = {w_rot_r, w_rot_i, w_idx, w_rot_sat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_pay   <= '0;
      r_skid_pay  <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_acc) begin
        r_cnt <= (w_idx == c_LAST_IDX) ? '0 : (w_idx + c_ONE);
      end else if (cnt_clr) begin
        r_cnt <= '0;
      end

      if (w_out_free) begin
        // A full skid blocks input, so it and a fresh accept never collide.
        if (!r_in_ready) begin
          r_out_pay   <= r_skid_pay;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
        end else if (w_acc) begin
          r_out_pay   <= w_pay;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid_pay <= w_pay;
        r_in_ready <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign {out_r, out_i, out_idx, out_sat} = r_out_pay;

endmodule

`default_nettype wire
